dds_select_stage: RTL and testbench



---
 rtl/dds_select_stage.sv | 83 ++++++++
 tb/tb_dds_select_stage.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/dds_select_stage.sv
// Quadrant-select stage of the DDS sine generator: folds the phase address into
// the quarter-wave LUT range and registers the selected magnitude with peak override.

module ANDmodule (
  input  logic a,
  input  logic b,
  output logic out
);
  assign out = a & b;
endmodule

module Mux_2_to_1_6bit (
  input  logic       SM,
  input  logic [5:0] a,
  input  logic [5:0] b,
  output logic [5:0] out
);
  assign out = SM ? b : a;
endmodule

module Mux_2_to_1_8bit (
  input  logic       SM,
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] out
);
  assign out = SM ? b : a;
endmodule

module dds_select_stage (
  input  logic       clk,
  input  logic       rst,
  input  logic       phase_pos,
  input  logic [5:0] addr,
  input  logic [5:0] addr_twos,
  input  logic       addr_zero,
  input  logic [7:0] rom_data,
  output logic [5:0] rom_addr,
  output logic       peak,
  output logic [7:0] mag_out
);
  localparam logic [7:0] PEAK_CODE = 8'hFF;

  logic       sel_peak_s;
  logic [7:0] mag_next_s;
  logic [7:0] mag_r;
  logic       peak_r;

  Mux_2_to_1_6bit u_addr_mux (
    .SM  (phase_pos),
    .a   (addr),
    .b   (addr_twos),
    .out (rom_addr)
  );

  // addr_twos wraps to 0 at the quarter-wave boundary, so the LUT cannot supply the peak there
  ANDmodule u_peak_and (
    .a   (addr_zero),
    .b   (phase_pos),
    .out (sel_peak_s)
  );

  Mux_2_to_1_8bit u_mag_mux (
    .SM  (sel_peak_s),
    .a   (rom_data),
    .b   (PEAK_CODE),
    .out (mag_next_s)
  );

  // Output register: every edge samples, async clear on rst low
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mag_r  <= 8'h00;
      peak_r <= 1'b0;
    end else begin
      mag_r  <= mag_next_s;
      peak_r <= sel_peak_s;
    end
  end

  assign mag_out = mag_r;
  assign peak    = peak_r;
endmodule

// File: tb/tb_dds_select_stage.sv
// Directed self-checking bench for dds_select_stage: reset, address folding,
// peak override, async mid-stream reset and back-to-back streaming.

module tb_dds_select_stage;
  logic       clk;
  logic       rst;
  logic       phase_pos;
  logic [5:0] addr;
  logic [5:0] addr_twos;
  logic       addr_zero;
  logic [7:0] rom_data;
  logic [5:0] rom_addr;
  logic       peak;
  logic [7:0] mag_out;

  int n_cmp;
  int n_fail;

  dds_select_stage dut (
    .clk       (clk),
    .rst       (rst),
    .phase_pos (phase_pos),
    .addr      (addr),
    .addr_twos (addr_twos),
    .addr_zero (addr_zero),
    .rom_data  (rom_data),
    .rom_addr  (rom_addr),
    .peak      (peak),
    .mag_out   (mag_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic pp, input logic [5:0] a, input logic [5:0] t,
                       input logic z, input logic [7:0] d);
    phase_pos = pp;
    addr      = a;
    addr_twos = t;
    addr_zero = z;
    rom_data  = d;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    drive(1'b1, 6'd5, 6'd59, 1'b0, 8'hA5);
    #2;
    n_cmp++;
    if (mag_out !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_mag_async: got %h expected %h", mag_out, 8'h00);
    end
    repeat (3) step();
    n_cmp++;
    if (mag_out !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_mag_hold: got %h expected %h", mag_out, 8'h00);
    end
    n_cmp++;
    if (peak !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_peak_hold: got %b expected %b", peak, 1'b0);
    end
    n_cmp++;
    if (rom_addr !== 6'd59) begin
      n_fail++;
      $display("FAIL reset_rom_addr: got %0d expected %0d", rom_addr, 59);
    end
    drive(1'b1, 6'd0, 6'd0, 1'b1, 8'h11);
    step();
    n_cmp++;
    if (peak !== 1'b0 || mag_out !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_ignores_peak: got peak=%b mag=%h expected peak=0 mag=00", peak, mag_out);
    end
    rst = 1'b1;
  endtask

  task automatic test_ascending();
    drive(1'b0, 6'd10, 6'd54, 1'b0, 8'h3C);
    #1;
    n_cmp++;
    if (rom_addr !== 6'd10) begin
      n_fail++;
      $display("FAIL asc_rom_addr: got %0d expected %0d", rom_addr, 10);
    end
    step();
    n_cmp++;
    if (mag_out !== 8'h3C || peak !== 1'b0) begin
      n_fail++;
      $display("FAIL asc_out: got mag=%h peak=%b expected mag=3c peak=0", mag_out, peak);
    end
  endtask

  task automatic test_mirrored();
    drive(1'b1, 6'd10, 6'd54, 1'b0, 8'hF0);
    #1;
    n_cmp++;
    if (rom_addr !== 6'd54) begin
      n_fail++;
      $display("FAIL mir_rom_addr: got %0d expected %0d", rom_addr, 54);
    end
    step();
    n_cmp++;
    if (mag_out !== 8'hF0 || peak !== 1'b0) begin
      n_fail++;
      $display("FAIL mir_out: got mag=%h peak=%b expected mag=f0 peak=0", mag_out, peak);
    end
  endtask

  task automatic test_peak();
    drive(1'b1, 6'd0, 6'd0, 1'b1, 8'h00);
    #1;
    n_cmp++;
    if (rom_addr !== 6'd0) begin
      n_fail++;
      $display("FAIL peak_rom_addr: got %0d expected %0d", rom_addr, 0);
    end
    step();
    n_cmp++;
    if (mag_out !== 8'hFF || peak !== 1'b1) begin
      n_fail++;
      $display("FAIL peak_out: got mag=%h peak=%b expected mag=ff peak=1", mag_out, peak);
    end
  endtask

  task automatic test_async_reset();
    // inputs still hold the peak-override vector from test_peak
    #2;
    rst = 1'b0;
    #1;
    n_cmp++;
    if (mag_out !== 8'h00 || peak !== 1'b0) begin
      n_fail++;
      $display("FAIL async_clear: got mag=%h peak=%b expected mag=00 peak=0", mag_out, peak);
    end
    #1;
    rst = 1'b1;
    #1;
    n_cmp++;
    if (mag_out !== 8'h00) begin
      n_fail++;
      $display("FAIL async_release_hold: got %h expected %h", mag_out, 8'h00);
    end
    step();
    n_cmp++;
    if (mag_out !== 8'hFF || peak !== 1'b1) begin
      n_fail++;
      $display("FAIL async_resume: got mag=%h peak=%b expected mag=ff peak=1", mag_out, peak);
    end
  endtask

  task automatic test_no_override();
    drive(1'b0, 6'd0, 6'd0, 1'b1, 8'h80);
    step();
    n_cmp++;
    if (mag_out !== 8'h80 || peak !== 1'b0) begin
      n_fail++;
      $display("FAIL no_override: got mag=%h peak=%b expected mag=80 peak=0", mag_out, peak);
    end
  endtask

  task automatic test_back_to_back();
    logic       v_pp [4];
    logic [5:0] v_a  [4];
    logic [5:0] v_t  [4];
    logic       v_z  [4];
    logic [7:0] v_d  [4];
    logic [5:0] e_ra [4];
    logic [7:0] e_m  [4];
    logic       e_p  [4];
    v_pp = '{1'b0, 1'b1, 1'b1, 1'b0};
    v_a  = '{6'd3, 6'd3, 6'd0, 6'd63};
    v_t  = '{6'd61, 6'd61, 6'd0, 6'd1};
    v_z  = '{1'b0, 1'b0, 1'b1, 1'b0};
    v_d  = '{8'h12, 8'h34, 8'h55, 8'hAA};
    e_ra = '{6'd3, 6'd61, 6'd0, 6'd63};
    e_m  = '{8'h12, 8'h34, 8'hFF, 8'hAA};
    e_p  = '{1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      drive(v_pp[i], v_a[i], v_t[i], v_z[i], v_d[i]);
      #1;
      n_cmp++;
      if (rom_addr !== e_ra[i]) begin
        n_fail++;
        $display("FAIL b2b_rom_addr[%0d]: got %0d expected %0d", i, rom_addr, e_ra[i]);
      end
      step();
      n_cmp++;
      if (mag_out !== e_m[i] || peak !== e_p[i]) begin
        n_fail++;
        $display("FAIL b2b_out[%0d]: got mag=%h peak=%b expected mag=%h peak=%b",
                 i, mag_out, peak, e_m[i], e_p[i]);
      end
    end
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    rst    = 1'b0;
    drive(1'b0, 6'd0, 6'd0, 1'b0, 8'h00);
    test_reset();
    test_ascending();
    test_mirrored();
    test_peak();
    test_async_reset();
    test_no_override();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
